// File: rtl/fp16_add_arb_if.sv
// Handshake bundle between two MAC lanes, the shared FP16 adder and the arbiter.
// FP16_ARB_CNT_EN adds the per-lane grant counters and their clear input.
interface fp16_add_arb_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [15:0] req0_a;
   logic [15:0] req0_b;
   logic        req1_valid;
   logic        req1_ready;
   logic [15:0] req1_a;
   logic [15:0] req1_b;
   logic        add_valid;
   logic [15:0] add_a;
   logic [15:0] add_b;
   logic [15:0] add_sum;
   logic        res0_valid;
   logic [15:0] res0_data;
   logic        res1_valid;
   logic [15:0] res1_data;
   logic        busy;
`ifdef FP16_ARB_CNT_EN
   logic        clr_cnt;
   logic [15:0] cnt0;
   logic [15:0] cnt1;
`endif

   modport slave (
      input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, add_sum,
      output req0_ready, req1_ready, add_valid, add_a, add_b,
      output res0_valid, res0_data, res1_valid, res1_data, busy
`ifdef FP16_ARB_CNT_EN
      , input clr_cnt
      , output cnt0, cnt1
`endif
   );

   modport master (
      output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, add_sum,
      input  req0_ready, req1_ready, add_valid, add_a, add_b,
      input  res0_valid, res0_data, res1_valid, res1_data, busy
`ifdef FP16_ARB_CNT_EN
      , output clr_cnt
      , input cnt0, cnt1
`endif
   );
endinterface

// File: rtl/fp16_add_arb.sv
// Round-robin arbiter sharing one pipelined FP16 adder between two MAC lanes.
// Optional FP16_ARB_CNT_EN: saturating per-lane handshake counters with sync clear.
module fp16_add_arb #(
   parameter int LAT = 3
) (
   input logic            clk,
   input logic            rst_n,
   fp16_add_arb_if.slave  bus
);
   logic           gnt0;
   logic           gnt1;
   logic           ptr_q;
   logic           add_valid_q;
   logic           lane_q;
   logic [15:0]    add_a_q;
   logic [15:0]    add_b_q;
   logic [LAT-1:0] tag_v_q;
   logic [LAT-1:0] tag_l_q;
   logic           res0_valid_q;
   logic           res1_valid_q;
   logic [15:0]    res0_data_q;
   logic [15:0]    res1_data_q;
   logic           exit0;
   logic           exit1;

   // ptr_q = 1 means lane 1 wins a contested cycle
   assign gnt0 = bus.req0_valid & (~bus.req1_valid | ~ptr_q);
   assign gnt1 = bus.req1_valid & (~bus.req0_valid |  ptr_q);

   assign exit0 = tag_v_q[LAT-1] & ~tag_l_q[LAT-1];
   assign exit1 = tag_v_q[LAT-1] &  tag_l_q[LAT-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q        <= 1'b0;
         add_valid_q  <= 1'b0;
         lane_q       <= 1'b0;
         add_a_q      <= 16'h0000;
         add_b_q      <= 16'h0000;
         tag_v_q      <= '0;
         tag_l_q      <= '0;
         res0_valid_q <= 1'b0;
         res1_valid_q <= 1'b0;
         res0_data_q  <= 16'h0000;
         res1_data_q  <= 16'h0000;
      end else begin
         if (gnt0 | gnt1) begin
            ptr_q <= gnt0;
         end
         add_valid_q <= gnt0 | gnt1;
         lane_q      <= gnt1;
         if (gnt0) begin
            add_a_q <= bus.req0_a;
            add_b_q <= bus.req0_b;
         end else if (gnt1) begin
            add_a_q <= bus.req1_a;
            add_b_q <= bus.req1_b;
         end
         // Tag enters one cycle after issue so it exits exactly when add_sum is valid
         tag_v_q[0] <= add_valid_q;
         tag_l_q[0] <= lane_q;
         for (int i = 1; i < LAT; i++) begin
            tag_v_q[i] <= tag_v_q[i-1];
            tag_l_q[i] <= tag_l_q[i-1];
         end
         res0_valid_q <= exit0;
         res1_valid_q <= exit1;
         if (exit0) begin
            res0_data_q <= bus.add_sum;
         end
         if (exit1) begin
            res1_data_q <= bus.add_sum;
         end
      end
   end

   assign bus.req0_ready = gnt0;
   assign bus.req1_ready = gnt1;
   assign bus.add_valid  = add_valid_q;
   assign bus.add_a      = add_a_q;
   assign bus.add_b      = add_b_q;
   assign bus.res0_valid = res0_valid_q;
   assign bus.res0_data  = res0_data_q;
   assign bus.res1_valid = res1_valid_q;
   assign bus.res1_data  = res1_data_q;
   assign bus.busy       = add_valid_q | (|tag_v_q) | res0_valid_q | res1_valid_q;

`ifdef FP16_ARB_CNT_EN
   logic [15:0] cnt0_q;
   logic [15:0] cnt1_q;

   // Clear wins over a coincident grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt0_q <= 16'h0000;
         cnt1_q <= 16'h0000;
      end else if (bus.clr_cnt) begin
         cnt0_q <= 16'h0000;
         cnt1_q <= 16'h0000;
      end else begin
         if (gnt0 && (cnt0_q != 16'hFFFF)) begin
            cnt0_q <= cnt0_q + 16'd1;
         end
         if (gnt1 && (cnt1_q != 16'hFFFF)) begin
            cnt1_q <= cnt1_q + 16'd1;
         end
      end
   end

   assign bus.cnt0 = cnt0_q;
   assign bus.cnt1 = cnt1_q;
`endif
endmodule

// File: tb/tb_fp16_add_arb.sv
// Bench for fp16_add_arb: table of per-cycle requests with expected grants and
// sums, plus hand sequences for busy timing, mid-flight reset and counters.
module tb_fp16_add_arb;
   localparam int LAT = 3;

   typedef struct {
      logic        v0;
      logic [15:0] a0;
      logic [15:0] b0;
      logic        v1;
      logic [15:0] a1;
      logic [15:0] b1;
      logic        r0;
      logic        r1;
      logic [15:0] sum;
   } vec_t;

   typedef struct {
      int          due;
      logic [15:0] a;
      logic [15:0] b;
   } iss_t;

   typedef struct {
      int          due;
      logic        lane;
      logic [15:0] sum;
   } res_t;

   logic        clk;
   logic        rst_n;
   int          cyc;
   int          n_chk;
   int          n_fail;
   int          last_cyc;
   bit          mon_en;
   bit          ea;
   bit          e0;
   bit          e1;
   iss_t        iq[$];
   res_t        rq[$];
   vec_t        tbl[13];
   logic [15:0] sum_pipe[LAT];

   fp16_add_arb_if bus ();

   fp16_add_arb #(.LAT(LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Exact-operand FP16 sums; swapped or wrong operands give 0xDEAD.
   function automatic logic [15:0] fp16_ref(input logic [15:0] a, input logic [15:0] b);
      case ({a, b})
         {16'h3C00, 16'h4000}: return 16'h4200;
         {16'h3800, 16'h3800}: return 16'h3C00;
         {16'h4000, 16'h4000}: return 16'h4400;
         {16'h4200, 16'h3C00}: return 16'h4400;
         {16'h3C00, 16'h3C00}: return 16'h4000;
         {16'h4400, 16'h4400}: return 16'h4800;
         {16'hBC00, 16'h3800}: return 16'hB800;
         {16'hC000, 16'h4000}: return 16'h0000;
         {16'h4000, 16'h4400}: return 16'h4600;
         default:              return 16'hDEAD;
      endcase
   endfunction

   // Adder model: X whenever no operation is in flight
   always @(posedge clk) begin
      sum_pipe[0] <= bus.add_valid ? fp16_ref(bus.add_a, bus.add_b) : 16'hxxxx;
      for (int i = 1; i < LAT; i++) sum_pipe[i] <= sum_pipe[i-1];
   end
   assign bus.add_sum = sum_pipe[LAT-1];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         ea = (iq.size() > 0) && (iq[0].due == cyc);
         check("add_valid", {31'd0, bus.add_valid}, {31'd0, ea});
         if (ea) begin
            check("add_a", {16'd0, bus.add_a}, {16'd0, iq[0].a});
            check("add_b", {16'd0, bus.add_b}, {16'd0, iq[0].b});
            iq.delete(0);
         end
         e0 = (rq.size() > 0) && (rq[0].due == cyc) && (rq[0].lane == 1'b0);
         e1 = (rq.size() > 0) && (rq[0].due == cyc) && (rq[0].lane == 1'b1);
         check("res0_valid", {31'd0, bus.res0_valid}, {31'd0, e0});
         check("res1_valid", {31'd0, bus.res1_valid}, {31'd0, e1});
         if (e0) check("res0_data", {16'd0, bus.res0_data}, {16'd0, rq[0].sum});
         if (e1) check("res1_data", {16'd0, bus.res1_data}, {16'd0, rq[0].sum});
         if (e0 || e1) rq.delete(0);
         check("res_data_known", {30'd0, $isunknown(bus.res0_data), $isunknown(bus.res1_data)}, 32'd0);
      end
   end

   task automatic drive(input vec_t v);
      bus.req0_valid = v.v0;
      bus.req0_a     = v.a0;
      bus.req0_b     = v.b0;
      bus.req1_valid = v.v1;
      bus.req1_a     = v.a1;
      bus.req1_b     = v.b1;
      @(negedge clk);
      check("req0_ready", {31'd0, bus.req0_ready}, {31'd0, v.r0});
      check("req1_ready", {31'd0, bus.req1_ready}, {31'd0, v.r1});
      last_cyc = cyc;
      if (v.r0) begin
         iq.push_back(iss_t'{cyc + 1, v.a0, v.b0});
         rq.push_back(res_t'{cyc + LAT + 2, 1'b0, v.sum});
      end else if (v.r1) begin
         iq.push_back(iss_t'{cyc + 1, v.a1, v.b1});
         rq.push_back(res_t'{cyc + LAT + 2, 1'b1, v.sum});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      cyc = 0; n_chk = 0; n_fail = 0; mon_en = 1'b0; last_cyc = 0;
      rst_n = 1'b0;
      bus.req0_valid = 1'b0; bus.req0_a = 16'h0; bus.req0_b = 16'h0;
      bus.req1_valid = 1'b0; bus.req1_a = 16'h0; bus.req1_b = 16'h0;
`ifdef FP16_ARB_CNT_EN
      bus.clr_cnt = 1'b0;
`endif

      //               v0    a0        b0        v1    a1        b1        r0    r1    sum
      tbl[0]  = '{1'b1, 16'h3C00, 16'h4000, 1'b1, 16'h3800, 16'h3800, 1'b1, 1'b0, 16'h4200};
      tbl[1]  = '{1'b1, 16'h4000, 16'h4000, 1'b1, 16'h3800, 16'h3800, 1'b0, 1'b1, 16'h3C00};
      tbl[2]  = '{1'b1, 16'h4000, 16'h4000, 1'b1, 16'h4200, 16'h3C00, 1'b1, 1'b0, 16'h4400};
      tbl[3]  = '{1'b1, 16'h4000, 16'h4400, 1'b1, 16'h4200, 16'h3C00, 1'b0, 1'b1, 16'h4400};
      tbl[4]  = '{1'b0, 16'h4000, 16'h4400, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000};
      tbl[5]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h3C00, 16'h3C00, 1'b0, 1'b1, 16'h4000};
      tbl[6]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h4400, 16'h4400, 1'b0, 1'b1, 16'h4800};
      tbl[7]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'hBC00, 16'h3800, 1'b0, 1'b1, 16'hB800};
      tbl[8]  = '{1'b1, 16'hC000, 16'h4000, 1'b1, 16'h3C00, 16'h3C00, 1'b1, 1'b0, 16'h0000};
      tbl[9]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h3C00, 16'h3C00, 1'b0, 1'b1, 16'h4000};
      tbl[10] = '{1'b1, 16'h3C00, 16'h4000, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h4200};
      tbl[11] = '{1'b1, 16'h4000, 16'h4400, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h4600};
      tbl[12] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000};

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_add_valid", {31'd0, bus.add_valid}, 32'd0);
      check("rst_add_a", {16'd0, bus.add_a}, 32'd0);
      check("rst_add_b", {16'd0, bus.add_b}, 32'd0);
      check("rst_res_valid", {30'd0, bus.res0_valid, bus.res1_valid}, 32'd0);
      check("rst_res0_data", {16'd0, bus.res0_data}, 32'd0);
      check("rst_res1_data", {16'd0, bus.res1_data}, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      mon_en = 1'b1;

      for (int i = 0; i < 13; i++) drive(tbl[i]);
      idle(LAT + 4);

      // Busy must drop the cycle after the final result pulse
      drive('{1'b1, 16'hC000, 16'h4000, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0000});
      idle(0);
      while (cyc < last_cyc + LAT + 2) @(negedge clk);
      check("busy_at_pulse", {31'd0, bus.busy}, 32'd1);
      @(negedge clk);
      check("busy_after_pulse", {31'd0, bus.busy}, 32'd0);
      check("res0_data_hold", {16'd0, bus.res0_data}, 32'd0);
      @(posedge clk);
      #1;

      // Two lane-0 ops in flight, then a one-cycle reset discards them
      drive('{1'b1, 16'h3C00, 16'h4000, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h4200});
      drive('{1'b1, 16'h4000, 16'h4000, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h4400});
      rst_n = 1'b0;
      iq.delete();
      rq.delete();
      idle(0);
      @(negedge clk);
      check("busy_in_reset", {31'd0, bus.busy}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(LAT + 4);
      @(negedge clk);
      check("busy_post_reset", {31'd0, bus.busy}, 32'd0);
      check("res0_data_post_reset", {16'd0, bus.res0_data}, 32'd0);
      @(posedge clk);
      #1;
      drive('{1'b1, 16'h3C00, 16'h3C00, 1'b1, 16'h4000, 16'h4000, 1'b1, 1'b0, 16'h4000});

`ifdef FP16_ARB_CNT_EN
      bus.clr_cnt = 1'b1;
      idle(1);
      bus.clr_cnt = 1'b0;
      repeat (5) drive('{1'b1, 16'h3C00, 16'h4000, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h4200});
      repeat (3) drive('{1'b0, 16'h0, 16'h0, 1'b1, 16'h3C00, 16'h4000, 1'b0, 1'b1, 16'h4200});
      idle(0);
      @(negedge clk);
      check("cnt0", {16'd0, bus.cnt0}, 32'd5);
      check("cnt1", {16'd0, bus.cnt1}, 32'd3);
      @(posedge clk);
      #1;
      bus.clr_cnt = 1'b1;
      drive('{1'b1, 16'h3C00, 16'h4000, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h4200});
      bus.clr_cnt = 1'b0;
      idle(0);
      @(negedge clk);
      check("cnt0_clr_grant", {16'd0, bus.cnt0}, 32'd0);
      check("cnt1_clr_grant", {16'd0, bus.cnt1}, 32'd0);
      @(posedge clk);
      #1;
`endif

      idle(LAT + 4);
      @(negedge clk);
      check("issue_queue_drained", iq.size(), 32'd0);
      check("result_queue_drained", rq.size(), 32'd0);
      check("busy_final", {31'd0, bus.busy}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
